// File: rtl/disp_write_sched_pkg.sv
// Shared display-bus definitions: register map, data width and scheduler state encoding.
package disp_write_sched_pkg;

  localparam int DISP_DATA_W = 10;
  localparam int POS_W       = 9;

  localparam logic [1:0] ADDR_BALL_X = 2'd0;
  localparam logic [1:0] ADDR_BALL_Y = 2'd1;
  localparam logic [1:0] ADDR_PAD1   = 2'd2;
  localparam logic [1:0] ADDR_PAD2   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CPU_WR = 2'd1,
    ST_BATCH  = 2'd2
  } state_t;

endpackage

// File: rtl/disp_write_sched.sv
// Display-bus write scheduler: arbitrates single CPU writes against atomic 4-register game
// batches, never starting a transaction while the frame-commit guard window is open.
module disp_write_sched
  import disp_write_sched_pkg::*;
#(
  parameter int GUARD_MIN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   commit_guard,
  input  logic                   cpu_req,
  input  logic [1:0]             cpu_addr,
  input  logic [DISP_DATA_W-1:0] cpu_data,
  output logic                   cpu_gnt,
  input  logic                   game_valid,
  input  logic [POS_W-1:0]       game_ball_x,
  input  logic [DISP_DATA_W-1:0] game_ball_y,
  input  logic [POS_W-1:0]       game_pad1,
  input  logic [POS_W-1:0]       game_pad2,
  output logic                   game_ready,
  output logic                   sel,
  output logic [1:0]             addr,
  output logic [DISP_DATA_W-1:0] data_out,
  output logic                   busy
);

  // A batch needs four bus cycles, so a shorter guard window could cut it at the commit.
  if (GUARD_MIN < 4) begin : g_guard_min_chk
    $error("GUARD_MIN must be at least 4");
  end

  function automatic logic [DISP_DATA_W-1:0] zext_pos(input logic [POS_W-1:0] v);
    return {{(DISP_DATA_W-POS_W){1'b0}}, v};
  endfunction

  state_t                 state, state_nxt;
  logic [1:0]             bcnt, bcnt_nxt;
  logic                   last_cpu, last_cpu_nxt;
  logic                   capture;
  logic                   grant_game, grant_cpu;

  logic [POS_W-1:0]       snap_x, snap_p1, snap_p2;
  logic [DISP_DATA_W-1:0] snap_y;

  logic                   sel_nxt, gnt_nxt, ready_nxt;
  logic [1:0]             addr_nxt;
  logic [DISP_DATA_W-1:0] data_nxt;

  always_comb begin
    state_nxt    = state;
    bcnt_nxt     = bcnt;
    last_cpu_nxt = last_cpu;
    capture      = 1'b0;
    sel_nxt      = 1'b0;
    addr_nxt     = '0;
    data_nxt     = '0;
    gnt_nxt      = 1'b0;
    ready_nxt    = 1'b0;
    // On a tie the source that did not win last time is served.
    grant_game   = game_valid && (!cpu_req || last_cpu);
    grant_cpu    = cpu_req && (!game_valid || !last_cpu);

    case (state)
      ST_IDLE: begin
        if (!commit_guard) begin
          if (grant_game) begin
            state_nxt    = ST_BATCH;
            bcnt_nxt     = 2'd0;
            capture      = 1'b1;
            last_cpu_nxt = 1'b0;
            sel_nxt      = 1'b1;
            addr_nxt     = ADDR_BALL_X;
            data_nxt     = zext_pos(game_ball_x);
            ready_nxt    = 1'b1;
          end else if (grant_cpu) begin
            state_nxt    = ST_CPU_WR;
            last_cpu_nxt = 1'b1;
            sel_nxt      = 1'b1;
            addr_nxt     = cpu_addr;
            data_nxt     = cpu_data;
            gnt_nxt      = 1'b1;
          end
        end
      end

      ST_CPU_WR: begin
        state_nxt = ST_IDLE;
      end

      ST_BATCH: begin
        // The guard is deliberately ignored here: a started batch always runs to completion.
        bcnt_nxt = bcnt + 2'd1;
        case (bcnt)
          2'd0: begin
            sel_nxt  = 1'b1;
            addr_nxt = ADDR_BALL_Y;
            data_nxt = snap_y;
          end
          2'd1: begin
            sel_nxt  = 1'b1;
            addr_nxt = ADDR_PAD1;
            data_nxt = zext_pos(snap_p1);
          end
          2'd2: begin
            sel_nxt  = 1'b1;
            addr_nxt = ADDR_PAD2;
            data_nxt = zext_pos(snap_p2);
          end
          default: begin
            state_nxt = ST_IDLE;
            bcnt_nxt  = 2'd0;
          end
        endcase
      end

      default: begin
        state_nxt = ST_IDLE;
        bcnt_nxt  = 2'd0;
      end
    endcase
  end

  // Registered control and bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bcnt       <= 2'd0;
      last_cpu   <= 1'b1;
      sel        <= 1'b0;
      addr       <= '0;
      data_out   <= '0;
      cpu_gnt    <= 1'b0;
      game_ready <= 1'b0;
    end else begin
      state      <= state_nxt;
      bcnt       <= bcnt_nxt;
      last_cpu   <= last_cpu_nxt;
      sel        <= sel_nxt;
      addr       <= addr_nxt;
      data_out   <= data_nxt;
      cpu_gnt    <= gnt_nxt;
      game_ready <= ready_nxt;
    end
  end

  // Snapshot of the coherent position set
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_x  <= '0;
      snap_y  <= '0;
      snap_p1 <= '0;
      snap_p2 <= '0;
    end else if (capture) begin
      snap_x  <= game_ball_x;
      snap_y  <= game_ball_y;
      snap_p1 <= game_pad1;
      snap_p2 <= game_pad2;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_disp_write_sched.sv
// Bench for disp_write_sched: expected bus writes (cycle, addr, data, gnt, ready) are queued
// as stimulus is applied and matched against every sel cycle.
module tb_disp_write_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       commit_guard = 1'b0;
  logic       cpu_req = 1'b0;
  logic [1:0] cpu_addr = 2'd0;
  logic [9:0] cpu_data = 10'd0;
  logic       cpu_gnt;
  logic       game_valid = 1'b0;
  logic [8:0] game_ball_x = 9'd0;
  logic [9:0] game_ball_y = 10'd0;
  logic [8:0] game_pad1 = 9'd0;
  logic [8:0] game_pad2 = 9'd0;
  logic       game_ready;
  logic       sel;
  logic [1:0] addr;
  logic [9:0] data_out;
  logic       busy;

  disp_write_sched #(.GUARD_MIN(4)) dut (
    .clk(clk), .rst(rst), .commit_guard(commit_guard),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_gnt(cpu_gnt),
    .game_valid(game_valid), .game_ball_x(game_ball_x), .game_ball_y(game_ball_y),
    .game_pad1(game_pad1), .game_pad2(game_pad2), .game_ready(game_ready),
    .sel(sel), .addr(addr), .data_out(data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] a;
    logic [9:0] d;
    logic       gnt;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_w(input int c, input logic [1:0] a, input logic [9:0] d,
                        input logic gnt, input logic rdy);
    exp_t e;
    e.cyc = c; e.a = a; e.d = d; e.gnt = gnt; e.rdy = rdy;
    q.push_back(e);
  endtask

  task automatic push_batch(input int c, input logic [8:0] x, input logic [9:0] y,
                            input logic [8:0] p1, input logic [8:0] p2);
    push_w(c,     2'd0, {1'b0, x},  1'b0, 1'b1);
    push_w(c + 1, 2'd1, y,          1'b0, 1'b0);
    push_w(c + 2, 2'd2, {1'b0, p1}, 1'b0, 1'b0);
    push_w(c + 3, 2'd3, {1'b0, p2}, 1'b0, 1'b0);
  endtask

  // One clock: pass the rising edge, then observe the bus on the falling edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (sel) begin
      if (q.size() == 0) begin
        chk("sel_unexpected", 32'(sel), 32'(0));
      end else begin
        e = q.pop_front();
        chk("wr_cycle", 32'(cyc), 32'(e.cyc));
        chk("wr_addr", 32'(addr), 32'(e.a));
        chk("wr_data", 32'(data_out), 32'(e.d));
        chk("wr_gnt", 32'(cpu_gnt), 32'(e.gnt));
        chk("wr_ready", 32'(game_ready), 32'(e.rdy));
      end
    end else begin
      chk("idle_bus", 32'({cpu_gnt, game_ready, addr, data_out}), 32'(0));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 40; k++) begin
      if (q.size() == 0 && !busy) break;
      tick();
    end
    if (k == 40) chk("drain_timeout", 32'(q.size()), 32'(0));
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    commit_guard = 1'b0; cpu_req = 1'b0; game_valid = 1'b0;
    ticks(3);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_sel", 32'(sel), 32'(0));
    rst = 1'b0;
  endtask

  int c;

  initial begin
    // Power-up batch of (100,200,50,60)
    do_reset();
    game_ball_x = 9'd100; game_ball_y = 10'd200; game_pad1 = 9'd50; game_pad2 = 9'd60;
    game_valid = 1'b1;
    c = cyc;
    push_batch(c + 1, 9'd100, 10'd200, 9'd50, 9'd60);
    ticks(2);
    game_valid = 1'b0;
    drain();

    // Simultaneous requests: game first, idle cycle, CPU wins the next tie, then game again
    do_reset();
    cpu_req = 1'b1; cpu_addr = 2'd2; cpu_data = 10'h2A5;
    game_ball_x = 9'h1FF; game_ball_y = 10'h3FF; game_pad1 = 9'h0AB; game_pad2 = 9'h155;
    game_valid = 1'b1;
    c = cyc;
    push_batch(c + 1, 9'h1FF, 10'h3FF, 9'h0AB, 9'h155);
    push_w(c + 6, 2'd2, 10'h2A5, 1'b1, 1'b0);
    push_batch(c + 8, 9'd5, 10'd6, 9'd7, 9'd8);
    tick();
    game_ball_x = 9'd5; game_ball_y = 10'd6; game_pad1 = 9'd7; game_pad2 = 9'd8;
    ticks(6);
    cpu_req = 1'b0;
    ticks(2);
    game_valid = 1'b0;
    drain();

    // CPU request held off by a 6-cycle guard window
    commit_guard = 1'b1;
    cpu_req = 1'b1; cpu_addr = 2'd3; cpu_data = 10'h155;
    c = cyc;
    push_w(c + 7, 2'd3, 10'h155, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("guard_busy", 32'(busy), 32'(0));
    end
    commit_guard = 1'b0;
    tick();
    cpu_req = 1'b0;
    drain();

    // Guard rises during batch write 2: batch completes, CPU waits for guard to fall
    game_ball_x = 9'h011; game_ball_y = 10'h222; game_pad1 = 9'h033; game_pad2 = 9'h144;
    game_valid = 1'b1;
    c = cyc;
    push_batch(c + 1, 9'h011, 10'h222, 9'h033, 9'h144);
    push_w(c + 9, 2'd1, 10'h0F0, 1'b1, 1'b0);
    ticks(2);
    game_valid = 1'b0;
    commit_guard = 1'b1;
    cpu_req = 1'b1; cpu_addr = 2'd1; cpu_data = 10'h0F0;
    ticks(6);
    commit_guard = 1'b0;
    tick();
    cpu_req = 1'b0;
    drain();

    // Reset during batch write 2 aborts it; held game_valid restarts a full batch
    game_ball_x = 9'h0AA; game_ball_y = 10'h155; game_pad1 = 9'h1CC; game_pad2 = 9'h033;
    game_valid = 1'b1;
    c = cyc;
    push_w(c + 1, 2'd0, 10'h0AA, 1'b0, 1'b1);
    push_w(c + 2, 2'd1, 10'h155, 1'b0, 1'b0);
    push_batch(c + 4, 9'h0AA, 10'h155, 9'h1CC, 9'h033);
    ticks(2);
    rst = 1'b1;
    tick();
    chk("rst_mid_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    ticks(2);
    game_valid = 1'b0;
    drain();

    chk("queue_empty", 32'(q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
